// File: rtl/approx_mult_pipe_if.sv
// Operand/result handshake bundle for approx_mult_pipe, plus the error-statistics side channel.
// The master drives operands and consumes results; the slave is the multiplier.
interface approx_mult_pipe_if #(
    parameter int W     = 8,
    parameter int ACC_W = 24,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_x;
    logic [W-1:0]     in_y;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_z;
    logic [1:0]       out_mode;
    logic             err_clr;
    logic [ACC_W-1:0] err_acc;
    logic [CNT_W-1:0] txn_cnt;

    modport master (
        output in_valid, in_x, in_y, in_mode, out_ready, err_clr,
        input  in_ready, out_valid, out_z, out_mode, err_acc, txn_cnt
    );

    modport slave (
        input  in_valid, in_x, in_y, in_mode, out_ready, err_clr,
        output in_ready, out_valid, out_z, out_mode, err_acc, txn_cnt
    );
endinterface

// File: rtl/approx_mult_pipe.sv
// Unsigned approximate multiplier (exact / truncated / OR-compressed low rows) with error statistics.
// Latency 2, one result per cycle; a stage advances only when the stage after it is empty or draining.
module approx_mult_pipe #(
    parameter int W     = 8,
    parameter int L     = 4,
    parameter int TC    = 7,
    parameter int ACC_W = 24,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    approx_mult_pipe_if.slave bus
);
    localparam int ZW = 2 * W;
    localparam int SW = ((ACC_W > ZW) ? ACC_W : ZW) + 1;
    // Columns below TC are dropped; a TC beyond the product width keeps nothing.
    localparam logic [ZW-1:0] C_LOW  = (ZW'(1) << TC) - ZW'(1);
    localparam logic [ZW-1:0] C_MASK = ~C_LOW;

    logic          w_in_fire;
    logic          w_s1_adv;
    logic          w_out_fire;
    logic [1:0]    w_mode;
    logic [ZW-1:0] w_h;
    logic [ZW-1:0] w_exact;
    logic [ZW-1:0] w_row [L];
    logic [ZW-1:0] w_comp_tr;
    logic [ZW-1:0] w_comp_or;
    logic [ZW-1:0] w_comp;
    logic [ZW-1:0] w_s2_z;
    logic [SW-1:0] w_sum;

    logic             r_s1_valid;
    logic [1:0]       r_s1_mode;
    logic [ZW-1:0]    r_s1_h;
    logic [ZW-1:0]    r_s1_comp;
    logic [ZW-1:0]    r_s1_exact;
    logic             r_s2_valid;
    logic [1:0]       r_s2_mode;
    logic [ZW-1:0]    r_s2_z;
    logic [ZW-1:0]    r_s2_err;
    logic [ACC_W-1:0] r_err_acc;
    logic [CNT_W-1:0] r_txn_cnt;

    assign w_out_fire   = r_s2_valid & bus.out_ready;
    assign w_s1_adv     = r_s1_valid & (~r_s2_valid | bus.out_ready);
    assign bus.in_ready = ~r_s1_valid | w_s1_adv;
    assign w_in_fire    = bus.in_valid & bus.in_ready;

    assign w_mode  = (bus.in_mode == 2'd3) ? 2'd0 : bus.in_mode;
    assign w_exact = ZW'(bus.in_x) * ZW'(bus.in_y);
    assign w_h     = (ZW'(bus.in_y) * ZW'(bus.in_x[W-1:L])) << L;

    // Row i already sits at its column offset, so pairing rows 2k/2k+1 bitwise
    // lines up pp[2k][c-2k] with pp[2k+1][c-2k-1] in every column c.
    for (genvar gi = 0; gi < L; gi++) begin : g_row
        assign w_row[gi] = bus.in_x[gi] ? (ZW'(bus.in_y) << gi) : '0;
    end

    always_comb begin
        w_comp_tr = '0;
        w_comp_or = '0;
        for (int i = 0; i < L; i++) begin
            w_comp_tr = w_comp_tr + (w_row[i] & C_MASK);
        end
        for (int k = 0; 2 * k + 1 < L; k++) begin
            w_comp_or = w_comp_or + ((w_row[2*k] | w_row[2*k+1]) & C_MASK);
        end
        if (L % 2 == 1) begin
            w_comp_or = w_comp_or + (w_row[L-1] & C_MASK);
        end
    end

    assign w_comp = (w_mode == 2'd1) ? w_comp_tr :
                    (w_mode == 2'd2) ? w_comp_or : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= '0;
            r_s1_h     <= '0;
            r_s1_comp  <= '0;
            r_s1_exact <= '0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_mode  <= w_mode;
            r_s1_h     <= w_h;
            r_s1_comp  <= w_comp;
            r_s1_exact <= w_exact;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    assign w_s2_z = (r_s1_mode == 2'd0) ? r_s1_exact : (r_s1_h + r_s1_comp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_mode  <= '0;
            r_s2_z     <= '0;
            r_s2_err   <= '0;
        end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_s2_mode  <= r_s1_mode;
            r_s2_z     <= w_s2_z;
            r_s2_err   <= r_s1_exact - w_s2_z;
        end else if (w_out_fire) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign w_sum = SW'(r_err_acc) + SW'(r_s2_err);

    // A clear in the same cycle as a delivery discards that delivery's contribution.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_acc <= '0;
            r_txn_cnt <= '0;
        end else if (bus.err_clr) begin
            r_err_acc <= '0;
            r_txn_cnt <= '0;
        end else if (w_out_fire) begin
            r_err_acc <= (w_sum > SW'({ACC_W{1'b1}})) ? '1 : w_sum[ACC_W-1:0];
            r_txn_cnt <= r_txn_cnt + 1'b1;
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.out_z     = r_s2_z;
    assign bus.out_mode  = r_s2_mode;
    assign bus.err_acc   = r_err_acc;
    assign bus.txn_cnt   = r_txn_cnt;
endmodule

// File: tb/tb_approx_mult_pipe.sv
// Scoreboard bench for approx_mult_pipe: directed operand pairs with hand-computed products,
// error sums, handshake stalls, saturation, clear-vs-transfer and mid-flight reset.
module tb_approx_mult_pipe;
    localparam int W     = 8;
    localparam int L     = 4;
    localparam int TC    = 7;
    localparam int ACC_W = 12;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [15:0] z;
        logic [1:0]  m;
    } exp_t;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [1:0]  m;
        logic [15:0] z;
        logic [1:0]  em;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   last_acc_cyc = 0;
    int   t3_acc0 = 0;
    exp_t exp_q[$];
    int   pop_cyc_q[$];
    vec_t t3_vec[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    approx_mult_pipe_if #(.W(W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    approx_mult_pipe #(.W(W), .L(L), .TC(TC), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, want);
        end
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [1:0] m,
                        input logic [15:0] ez, input logic [1:0] em);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_mode  = m;
        #1;
        while (!bus.in_ready && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (bus.in_ready) begin
            e.z = ez;
            e.m = em;
            exp_q.push_back(e);
            last_acc_cyc = cyc;
        end else begin
            chk("send_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk({nm, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(bus.out_z), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_z", 32'(bus.out_z), 32'(e.z));
                    chk("out_mode", 32'(bus.out_mode), 32'(e.m));
                    pop_cyc_q.push_back(cyc);
                end
            end
        end
    end

    initial begin
        logic [31:0] tmp;
        t3_vec[0] = '{8'd255, 8'd255, 2'd0, 16'd65025, 2'd0};
        t3_vec[1] = '{8'd255, 8'd255, 2'd1, 16'd64528, 2'd1};
        t3_vec[2] = '{8'd255, 8'd255, 2'd2, 16'd63504, 2'd2};
        t3_vec[3] = '{8'd15,  8'd255, 2'd1, 16'd3328,  2'd1};
        t3_vec[4] = '{8'd15,  8'd128, 2'd1, 16'd1920,  2'd1};
        t3_vec[5] = '{8'd3,   8'd192, 2'd2, 16'd384,   2'd2};
        t3_vec[6] = '{8'd3,   8'd192, 2'd1, 16'd512,   2'd1};
        t3_vec[7] = '{8'd15,  8'd128, 2'd2, 16'd1920,  2'd2};

        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b1;
        bus.err_clr   = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_z", 32'(bus.out_z), 32'd0);
        chk("rst_out_mode", 32'(bus.out_mode), 32'd0);
        chk("rst_err_acc", 32'(bus.err_acc), 32'd0);
        chk("rst_txn_cnt", 32'(bus.txn_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // T1: all-ones operands in each mode
        send(8'd255, 8'd255, 2'd0, 16'd65025, 2'd0);
        send(8'd255, 8'd255, 2'd1, 16'd64528, 2'd1);
        send(8'd255, 8'd255, 2'd2, 16'd63504, 2'd2);
        drain("t1");
        chk("t1_err_acc", 32'(bus.err_acc), 32'd2018);
        chk("t1_txn_cnt", 32'(bus.txn_cnt), 32'd3);

        // T2: no low multiplier bits set, then a product that truncates to zero
        for (int m = 0; m < 3; m++) send(8'd16, 8'd10, 2'(m), 16'd160, 2'(m));
        drain("t2a");
        chk("t2_err_unchanged", 32'(bus.err_acc), 32'd2018);
        send(8'd3, 8'd5, 2'd1, 16'd0, 2'd1);
        drain("t2b");
        chk("t2_err_acc", 32'(bus.err_acc), 32'd2033);
        chk("t2_txn_cnt", 32'(bus.txn_cnt), 32'd7);

        // T3: back-to-back stream
        clear_stats();
        chk("t3_clr_err", 32'(bus.err_acc), 32'd0);
        chk("t3_clr_cnt", 32'(bus.txn_cnt), 32'd0);
        pop_cyc_q.delete();
        for (int i = 0; i < 8; i++) begin
            send(t3_vec[i].x, t3_vec[i].y, t3_vec[i].m, t3_vec[i].z, t3_vec[i].em);
            if (i == 0) t3_acc0 = last_acc_cyc;
        end
        drain("t3");
        chk("t3_results", 32'(pop_cyc_q.size()), 32'd8);
        if (pop_cyc_q.size() == 8) begin
            chk("t3_latency", 32'(pop_cyc_q[0] - t3_acc0), 32'd2);
            chk("t3_throughput", 32'(pop_cyc_q[7] - pop_cyc_q[0]), 32'd7);
        end
        chk("t3_err_acc", 32'(bus.err_acc), 32'd2771);
        chk("t3_txn_cnt", 32'(bus.txn_cnt), 32'd8);

        // T4: consumer stalls with three operands offered
        bus.out_ready = 1'b0;
        fork
            begin
                send(8'd200, 8'd3, 2'd0, 16'd600, 2'd0);
                send(8'd7, 8'd9, 2'd1, 16'd0, 2'd1);
                send(8'd255, 8'd1, 2'd0, 16'd255, 2'd0);
            end
            begin
                repeat (3) @(negedge clk);
                #3;
                chk("t4_in_ready_low", 32'(bus.in_ready), 32'd0);
                chk("t4_out_valid", 32'(bus.out_valid), 32'd1);
                chk("t4_held_z", 32'(bus.out_z), 32'd600);
                @(negedge clk);
                #3;
                chk("t4_z_stable", 32'(bus.out_z), 32'd600);
                chk("t4_mode_stable", 32'(bus.out_mode), 32'd0);
                chk("t4_still_blocked", 32'(bus.in_ready), 32'd0);
                @(negedge clk);
                bus.out_ready = 1'b1;
            end
        join
        drain("t4");
        chk("t4_err_acc", 32'(bus.err_acc), 32'd2834);
        chk("t4_txn_cnt", 32'(bus.txn_cnt), 32'd11);

        // T5: saturation, then clear colliding with a delivery
        clear_stats();
        send(8'd255, 8'd255, 2'd2, 16'd63504, 2'd2);
        send(8'd255, 8'd255, 2'd2, 16'd63504, 2'd2);
        drain("t5a");
        chk("t5_err_pre_sat", 32'(bus.err_acc), 32'd3042);
        send(8'd255, 8'd255, 2'd2, 16'd63504, 2'd2);
        send(8'd255, 8'd255, 2'd2, 16'd63504, 2'd2);
        drain("t5b");
        chk("t5_err_sat", 32'(bus.err_acc), 32'd4095);
        chk("t5_txn_cnt", 32'(bus.txn_cnt), 32'd4);
        send(8'd16, 8'd10, 2'd0, 16'd160, 2'd0);
        @(negedge clk);
        @(negedge clk);
        bus.err_clr = 1'b1;
        #1;
        chk("t5_clr_xfer_vld", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        tmp = 32'(bus.err_acc);
        chk("t5_clr_err", tmp, 32'd0);
        chk("t5_clr_cnt", 32'(bus.txn_cnt), 32'd0);
        drain("t5c");

        // T6: reserved mode, then reset with two results in flight
        send(8'd255, 8'd255, 2'd3, 16'd65025, 2'd0);
        drain("t6a");
        chk("t6_txn_cnt", 32'(bus.txn_cnt), 32'd1);
        chk("t6_err_acc", 32'(bus.err_acc), 32'd0);
        bus.out_ready = 1'b0;
        send(8'd15, 8'd255, 2'd1, 16'd3328, 2'd1);
        send(8'd3, 8'd192, 2'd2, 16'd384, 2'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        chk("t6_no_output", 32'(bus.out_valid), 32'd0);
        chk("t6_post_rst_cnt", 32'(bus.txn_cnt), 32'd0);
        chk("t6_post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
